fc_neuron_sequencer: RTL

- Controller and result consumer on the far side of the fully-connected MAC unit interface. The MAC unit is the block that streams image/filter pairs into the processing element and raises over_flag when finished.
- For each of NUM_NEURONS output neurons, this block:
  - pulses the MAC unit's reset,
  - presents the neuron index so the upstream mux selects that neuron's filter row,
  - waits for over_flag, then captures the accumulated FP16 result.
- Packs all neuron results into one flat output vector for the next layer.
- Includes a watchdog so a stalled MAC unit cannot hang the layer.

---
 rtl/fc_neuron_if.sv | 28 ++
 rtl/fc_neuron_sequencer.sv | 126 ++++++++++++
 2 files changed

// File: rtl/fc_neuron_if.sv
// Sequencer-side bundle for the FC layer: MAC-unit control/result and layer outputs.
// The sequencer drives through the master modport; the environment uses slave.
interface fc_neuron_if #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned NUM_NEURONS = 10
);
    localparam int unsigned IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

    logic                              start;
    logic                              over_flag;
    logic [DATA_WIDTH-1:0]             result_in;
    logic                              fc_reset;
    logic [IDX_W-1:0]                  neuron_idx;
    logic [NUM_NEURONS*DATA_WIDTH-1:0] out_vector;
    logic                              out_valid;
    logic                              busy;
    logic                              timeout_err;

    modport master (
        input  start, over_flag, result_in,
        output fc_reset, neuron_idx, out_vector, out_valid, busy, timeout_err
    );

    modport slave (
        output start, over_flag, result_in,
        input  fc_reset, neuron_idx, out_vector, out_valid, busy, timeout_err
    );
endinterface

// File: rtl/fc_neuron_sequencer.sv
// Walks NUM_NEURONS neurons through the MAC unit (reset, run, capture) with a per-neuron watchdog.
// Optional macro FC_RELU_EN clamps negative captured results to zero.
module fc_neuron_sequencer #(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned NUM_NEURONS   = 10,
    parameter int unsigned NUM_INPUTS    = 100,
    parameter int unsigned RESET_CYCLES  = 2,
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned TIMEOUT_SLACK = 8
) (
    input  logic            clk,
    input  logic            reset,
    fc_neuron_if.master     bus
);
    localparam int unsigned IDX_W       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam int unsigned VEC_W       = NUM_NEURONS * DATA_WIDTH;
    localparam int unsigned WD_LIMIT    = NUM_INPUTS + 2 + TIMEOUT_SLACK;
    localparam int unsigned WD_W        = $clog2(WD_LIMIT + 1);
    localparam int unsigned CNT_MAX     = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
    localparam int unsigned CNT_W       = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned SETTLE_LAST = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_RUN, S_SETTLE, S_CAPTURE, S_NEXT, S_DONE
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WD_W-1:0]    wd_q;
    logic [IDX_W-1:0]   neuron_idx_q;
    logic [VEC_W-1:0]   out_vector_q;
    logic               fc_reset_q;
    logic               out_valid_q;
    logic               busy_q;
    logic               timeout_err_q;
    logic [DATA_WIDTH-1:0] capture_val;

`ifdef FC_RELU_EN
    assign capture_val = bus.result_in[DATA_WIDTH-1] ? '0 : bus.result_in;
`else
    assign capture_val = bus.result_in;
`endif

    // Sequencer FSM; every output is a register updated on the transition into its state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            wd_q          <= '0;
            neuron_idx_q  <= '0;
            out_vector_q  <= '0;
            fc_reset_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        state_q       <= S_CLEAR;
                        cnt_q         <= '0;
                        neuron_idx_q  <= '0;
                        fc_reset_q    <= 1'b1;
                        out_valid_q   <= 1'b0;
                        timeout_err_q <= 1'b0;
                        busy_q        <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    if (cnt_q == CNT_W'(RESET_CYCLES - 1)) begin
                        state_q    <= S_RUN;
                        cnt_q      <= '0;
                        wd_q       <= '0;
                        fc_reset_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_RUN: begin
                    // Completion takes priority over a coincident watchdog expiry.
                    if (bus.over_flag) begin
                        cnt_q   <= '0;
                        state_q <= (SETTLE_CYCLES == 0) ? S_CAPTURE : S_SETTLE;
                    end else if (wd_q == WD_W'(WD_LIMIT - 1)) begin
                        timeout_err_q <= 1'b1;
                        out_vector_q[int'(neuron_idx_q) * DATA_WIDTH +: DATA_WIDTH] <= '0;
                        state_q       <= S_NEXT;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                    end
                end
                S_SETTLE: begin
                    if (cnt_q == CNT_W'(SETTLE_LAST)) begin
                        state_q <= S_CAPTURE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_CAPTURE: begin
                    out_vector_q[int'(neuron_idx_q) * DATA_WIDTH +: DATA_WIDTH] <= capture_val;
                    state_q <= S_NEXT;
                end
                S_NEXT: begin
                    fc_reset_q <= 1'b1;
                    cnt_q      <= '0;
                    if (neuron_idx_q == IDX_W'(NUM_NEURONS - 1)) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end else begin
                        neuron_idx_q <= neuron_idx_q + IDX_W'(1);
                        state_q      <= S_CLEAR;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.fc_reset    = fc_reset_q;
    assign bus.neuron_idx  = neuron_idx_q;
    assign bus.out_vector  = out_vector_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.busy        = busy_q;
    assign bus.timeout_err = timeout_err_q;
endmodule
